// File: rtl/cordic_launcher_if.sv
// Request, core and result signal bundle for cordic_launcher.
// Both handshakes: a transfer happens on a rising edge where valid and ready are both high.
interface cordic_launcher_if #(
    parameter int BIT_WIDTH = 16
);
    logic                 in_valid;
    logic                 in_ready;
    logic [BIT_WIDTH-1:0] in_angle;
    logic                 core_start;
    logic [BIT_WIDTH-1:0] core_target;
    logic                 core_done;
    logic [BIT_WIDTH-1:0] core_x;
    logic [BIT_WIDTH-1:0] core_y;
    logic                 out_valid;
    logic                 out_ready;
    logic [BIT_WIDTH-1:0] out_x;
    logic [BIT_WIDTH-1:0] out_y;
    logic                 out_err;

    // slave: the launcher itself; master: requester, core and result consumer
    modport slave (
        input  in_valid, in_angle, core_done, core_x, core_y, out_ready,
        output in_ready, core_start, core_target, out_valid, out_x, out_y, out_err
    );
    modport master (
        output in_valid, in_angle, core_done, core_x, core_y, out_ready,
        input  in_ready, core_start, core_target, out_valid, out_x, out_y, out_err
    );
endinterface

// File: rtl/cordic_launcher.sv
// CORDIC front-end: folds the request angle into [-pi/2, pi/2), starts the core,
// collects and unfolds its result, and aborts a hung compute with a watchdog.
module cordic_launcher #(
    parameter int BIT_WIDTH = 16,
    parameter int TIMEOUT   = 64
) (
    input  logic               clk,
    input  logic               reset,
    cordic_launcher_if.slave   bus,
    output logic [2:0]         o_dbg_state
);
    localparam int              CW   = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0]   TMAX = CW'(TIMEOUT);
    localparam logic [BIT_WIDTH-1:0] MIN_VAL = {1'b1, {(BIT_WIDTH-1){1'b0}}};
    localparam logic [BIT_WIDTH-1:0] MAX_VAL = {1'b0, {(BIT_WIDTH-1){1'b1}}};

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_START    = 3'd1,
        S_WAIT_LOW = 3'd2,
        S_BUSY     = 3'd3,
        S_OUT      = 3'd4
    } state_t;

    state_t               r_state;
    logic                 r_flip;
    logic [CW-1:0]        r_cnt;
    logic                 r_in_ready;
    logic                 r_core_start;
    logic [BIT_WIDTH-1:0] r_core_target;
    logic                 r_out_valid;
    logic [BIT_WIDTH-1:0] r_out_x;
    logic [BIT_WIDTH-1:0] r_out_y;
    logic                 r_out_err;

    logic                 w_flip;
    logic [BIT_WIDTH-1:0] w_folded;
    logic [BIT_WIDTH-1:0] w_cap_x;
    logic [BIT_WIDTH-1:0] w_cap_y;
    logic [CW-1:0]        w_cnt_next;

    // The most negative value has no positive twin, so it clamps to the maximum.
    function automatic logic [BIT_WIDTH-1:0] sat_neg(input logic [BIT_WIDTH-1:0] v);
        if (v == MIN_VAL) return MAX_VAL;
        return -v;
    endfunction

    assign w_flip     = bus.in_angle[BIT_WIDTH-1] ^ bus.in_angle[BIT_WIDTH-2];
    assign w_folded   = {~bus.in_angle[BIT_WIDTH-1], bus.in_angle[BIT_WIDTH-2:0]};
    assign w_cap_x    = r_flip ? sat_neg(bus.core_x) : bus.core_x;
    assign w_cap_y    = r_flip ? sat_neg(bus.core_y) : bus.core_y;
    assign w_cnt_next = r_cnt + CW'(1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= S_IDLE;
            r_flip        <= 1'b0;
            r_cnt         <= '0;
            r_in_ready    <= 1'b0;
            r_core_start  <= 1'b0;
            r_core_target <= '0;
            r_out_valid   <= 1'b0;
            r_out_x       <= '0;
            r_out_y       <= '0;
            r_out_err     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.in_valid && r_in_ready) begin
                        r_flip        <= w_flip;
                        r_core_target <= w_flip ? w_folded : bus.in_angle;
                        r_in_ready    <= 1'b0;
                        r_core_start  <= 1'b1;
                        r_state       <= S_START;
                    end else begin
                        r_in_ready <= 1'b1;
                    end
                end
                S_START: begin
                    r_core_start <= 1'b0;
                    r_cnt        <= '0;
                    r_state      <= S_WAIT_LOW;
                end
                // A done level that never drops can only end in the watchdog.
                S_WAIT_LOW: begin
                    r_cnt <= w_cnt_next;
                    if (w_cnt_next == TMAX) begin
                        r_out_x     <= '0;
                        r_out_y     <= '0;
                        r_out_err   <= 1'b1;
                        r_out_valid <= 1'b1;
                        r_state     <= S_OUT;
                    end else if (!bus.core_done) begin
                        r_state <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    r_cnt <= w_cnt_next;
                    if (bus.core_done) begin
                        r_out_x     <= w_cap_x;
                        r_out_y     <= w_cap_y;
                        r_out_err   <= 1'b0;
                        r_out_valid <= 1'b1;
                        r_state     <= S_OUT;
                    end else if (w_cnt_next == TMAX) begin
                        r_out_x     <= '0;
                        r_out_y     <= '0;
                        r_out_err   <= 1'b1;
                        r_out_valid <= 1'b1;
                        r_state     <= S_OUT;
                    end
                end
                S_OUT: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready    = r_in_ready;
    assign bus.core_start  = r_core_start;
    assign bus.core_target = r_core_target;
    assign bus.out_valid   = r_out_valid;
    assign bus.out_x       = r_out_x;
    assign bus.out_y       = r_out_y;
    assign bus.out_err     = r_out_err;
    assign o_dbg_state     = r_state;
endmodule
